// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
// Optional misaligned-fetch (ADEF) check is enabled by defining IF_ADEF_CHECK_EN.
package if_stage_pkg;

    localparam int unsigned PC_W   = 32;
    localparam int unsigned INST_W = 32;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam pc_t   RESET_PC_DEF   = 32'h1c000000;
    localparam inst_t NOP_INST_DEF   = 32'h03400000;
    localparam pc_t   PC_STEP        = 32'd4;

    localparam logic [3:0] SRAM_WE_TIE    = '0;
    localparam inst_t      SRAM_WDATA_TIE = '0;

    function automatic logic pc_misaligned(input pc_t pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Decode handshake, branch redirect and instruction-SRAM bus of the fetch stage.
// fs_adef is present only when IF_ADEF_CHECK_EN is defined.
interface if_stage_if;
    import if_stage_pkg::*;

    logic       br_taken;
    pc_t        br_target;
    logic       out_ready;
    logic       out_valid;
    inst_t      inst_out;
    pc_t        PC_out;
    logic       inst_sram_en;
    logic [3:0] inst_sram_we;
    pc_t        inst_sram_addr;
    inst_t      inst_sram_wdata;
    inst_t      inst_sram_rdata;
`ifdef IF_ADEF_CHECK_EN
    logic       fs_adef;

    modport master (
        input  br_taken, br_target, out_ready, inst_sram_rdata,
        output out_valid, inst_out, PC_out, fs_adef,
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output br_taken, br_target, out_ready, inst_sram_rdata,
        input  out_valid, inst_out, PC_out, fs_adef,
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );
`else
    modport master (
        input  br_taken, br_target, out_ready, inst_sram_rdata,
        output out_valid, inst_out, PC_out,
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output br_taken, br_target, out_ready, inst_sram_rdata,
        input  out_valid, inst_out, PC_out,
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );
`endif

endinterface

// File: rtl/if_inst_buf.sv
// One-entry skid register that holds the SRAM read data while decode stalls.
module if_inst_buf
    import if_stage_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  capture,
    input  logic  clear,
    input  inst_t din,
    output logic  valid,
    output inst_t data
);

    // clear has priority so a kill in the capture cycle leaves nothing behind
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            data  <= din;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC mux, SRAM issue and decode handshake.
// Define IF_ADEF_CHECK_EN to flag misaligned fetches (fs_adef) and freeze until redirect.
module if_stage
    import if_stage_pkg::*;
#(
    parameter pc_t   RESET_PC = RESET_PC_DEF,
    parameter inst_t NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        resetn,
    if_stage_if.master  bus
);

    logic  resetn_q;
    logic  fs_valid;
    pc_t   fs_pc;
    logic  br_pend;
    pc_t   br_tgt_r;

    pc_t   next_pc;
    logic  allowin;
    logic  stall_kill;
    logic  issue;
    logic  out_valid;
    logic  transfer;

    logic  buf_valid;
    inst_t inst_buf;
    logic  buf_capture;
    logic  buf_clear;

    always_comb begin
        next_pc = fs_pc + PC_STEP;
        if (bus.br_taken) begin
            next_pc = bus.br_target;
        end else if (br_pend) begin
            next_pc = br_tgt_r;
        end
    end

`ifdef IF_ADEF_CHECK_EN
    logic redirect;
    logic adef_r;
    logic fetch_bad;

    assign redirect   = bus.br_taken | br_pend;
    assign fetch_bad  = pc_misaligned(next_pc);
    assign stall_kill = adef_r & ~redirect;
    // the freeze must also hold once the faulting PC has drained to decode
    assign allowin    = (~fs_valid | bus.out_ready) & ~stall_kill;
    assign issue      = resetn_q & allowin;
    assign bus.inst_sram_en = issue & ~fetch_bad;
    assign bus.fs_adef      = out_valid & adef_r;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            adef_r <= 1'b0;
        end else if (issue) begin
            adef_r <= fetch_bad;
        end
    end
`else
    assign stall_kill = 1'b0;
    assign allowin    = ~fs_valid | (bus.out_ready & ~stall_kill);
    assign issue      = resetn_q & allowin;
    assign bus.inst_sram_en = issue;
`endif

    assign bus.inst_sram_addr  = next_pc;
    assign bus.inst_sram_we    = SRAM_WE_TIE;
    assign bus.inst_sram_wdata = SRAM_WDATA_TIE;

    assign out_valid     = fs_valid & ~bus.br_taken;
    assign transfer      = out_valid & bus.out_ready;
    assign bus.out_valid = out_valid;
    assign bus.PC_out    = fs_pc;

    always_comb begin
        bus.inst_out = NOP_INST;
        if (out_valid) begin
            bus.inst_out = buf_valid ? inst_buf : bus.inst_sram_rdata;
`ifdef IF_ADEF_CHECK_EN
            if (adef_r) begin
                bus.inst_out = NOP_INST;
            end
`endif
        end
    end

    assign buf_capture = fs_valid & ~bus.out_ready & ~buf_valid;
    assign buf_clear   = issue | transfer | bus.br_taken;

    if_inst_buf u_inst_buf (
        .clk     (clk),
        .resetn  (resetn),
        .capture (buf_capture),
        .clear   (buf_clear),
        .din     (bus.inst_sram_rdata),
        .valid   (buf_valid),
        .data    (inst_buf)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            resetn_q <= 1'b0;
            fs_valid <= 1'b0;
            fs_pc    <= RESET_PC - PC_STEP;
            br_pend  <= 1'b0;
            br_tgt_r <= '0;
        end else begin
            resetn_q <= 1'b1;
            if (bus.br_taken) begin
                br_tgt_r <= bus.br_target;
            end
            if (issue) begin
                fs_valid <= 1'b1;
                fs_pc    <= next_pc;
                br_pend  <= 1'b0;
            end else begin
                if (transfer || bus.br_taken) begin
                    fs_valid <= 1'b0;
                end
                if (bus.br_taken) begin
                    br_pend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage LoongArch pipeline.
- Owns the PC and a pre-IF next-PC mux, and drives the synchronous instruction SRAM (1-cycle read latency).
- Buffers returned instructions under back-pressure and delivers {inst, PC} to the decode stage over a valid/ready handshake.
- Accepts branch redirects from decode and squashes the wrong-path instruction.

Parameters:
- RESET_PC, 32'h1c000000, address of first fetch after reset.
- NOP_INST, 32'h03400000, value driven on inst_out when out_valid=0.

Ports:
- clk  in  1  stage clock; all state updates on posedge.
- resetn  in  1  reset; synchronous, active-low.
- br_taken  in  1  redirect pulse from decode; valid only in the cycle decode fires.
- br_target  in  32  redirect address; sampled when br_taken=1.
- out_ready  in  1  decode in_ready.
- out_valid  out  1  {inst_out, PC_out} valid to decode.
- inst_out  out  32  fetched instruction.
- PC_out  out  32  PC of inst_out.
- inst_sram_en  out  1  SRAM read enable.
- inst_sram_we  out  4  tied 4'b0.
- inst_sram_addr  out  32  fetch address (= next_pc).
- inst_sram_wdata  out  32  tied 0.
- inst_sram_rdata  in  32  data for the address issued in the previous cycle.

Behaviour:
- Reset (resetn=0 at posedge):
  - fs_valid=0, fs_pc=RESET_PC-4, buf_valid=0, br_pend=0.
  - Outputs: out_valid=0, inst_sram_en=0, inst_out=NOP_INST, PC_out=RESET_PC-4.
  - Reset mid-operation discards any in-flight fetch, buffered instruction and pending branch.
- Internal signals:
  - allowin = ~fs_valid | (out_ready & ~stall_kill).
  - redirect = br_taken | br_pend.
  - next_pc = br_taken ? br_target : br_pend ? br_tgt_r : fs_pc+4 (wraps mod 2^32).
- Fetch issue:
  - inst_sram_en = resetn_q & allowin, where resetn_q is resetn registered, so the first fetch occurs the cycle after reset deasserts.
  - inst_sram_addr = next_pc.
  - On issue: fs_pc<=next_pc, fs_valid<=1, buf_valid<=0, br_pend<=0.
- Output handshake:
  - out_valid = fs_valid & ~br_taken; PC_out=fs_pc.
  - inst_out = buf_valid ? inst_buf : inst_sram_rdata when out_valid, else NOP_INST.
  - Transfer occurs when out_valid & out_ready.
  - Transfer without a simultaneous issue: fs_valid<=0.
- Back-pressure buffer:
  - When fs_valid & ~out_ready & ~buf_valid, capture inst_buf<=inst_sram_rdata and set buf_valid<=1.
  - SRAM output is not required to hold.
  - buf_valid clears on transfer or kill.
- Branch:
  - br_taken kills the current IF instruction: it is never presented valid, and fs_valid is cleared unless a new fetch issues.
  - If allowin=1 in the same cycle, fetch br_target immediately.
  - Otherwise latch br_pend=1, br_tgt_r=br_target; the pending redirect wins over sequential PC at the next issue.
  - A second br_taken while br_pend=1 overwrites br_tgt_r.
- Latency: redirect to target valid at decode = 1 cycle; sustained throughput 1 inst/cycle with out_ready=1.
- stall_kill is 0 unless IF_ADEF_CHECK_EN is defined.

Optional Feature:
- Macro: IF_ADEF_CHECK_EN.
- Defined:
  - Adds output fs_adef (1 bit).
  - If next_pc[1:0]!=0, the fetch is not sent to SRAM (inst_sram_en=0) but fs_valid/fs_pc still update.
  - fs_adef=1 and inst_out=NOP_INST accompany that PC to decode.
  - fs_adef resets to 0.
  - Fetching stops (stall_kill=1, allowin=0) until a redirect arrives.
- Undefined: no fs_adef port; misaligned addresses are issued unchanged (low bits forwarded to SRAM).

Decomposition:
- Shared package/header: RESET_PC, NOP_INST, PC width 32, SRAM we/wdata tie-off constants.
- One natural sub-module: if_inst_buf, a 1-entry skid register holding inst_buf/buf_valid with capture/clear inputs.

Test Plan:
- Reset release, out_ready=1, SRAM returns addr as data → first inst_sram_addr=0x1c000000; then 0x1c000004, 0x1c000008 on consecutive cycles; out_valid=1 from cycle 2, PC_out tracks.
- Hold out_ready=0 for 3 cycles while SRAM rdata changes to garbage → inst_out stays the value captured in the first stall cycle; inst_sram_en=0 during stall; resumes at PC+4.
- br_taken=1, br_target=0x1c000100 while IF holds 0x1c000008 → 0x1c000008 never valid at decode; next valid PC_out=0x1c000100.
- br_taken while out_ready=0 and fs_valid=1 → br_pend set; first issue after stall is 0x1c000100, not PC+4.
- Assert resetn=0 mid-stream with buf_valid=1 and br_pend=1 → next cycle out_valid=0, inst_sram_en=0; after release fetch restarts at 0x1c000000.
- (IF_ADEF_CHECK_EN) br_target=0x1c000102 → fs_adef=1, inst_out=0x03400000, no SRAM access, fetch frozen until the next br_taken.
